lfsr_prbs_checker: RTL and testbench

LFSR_PRBS_CHECKER -- requirements
Module: lfsr_prbs_checker

---
 rtl/lfsr_prbs_checker.sv | 136 +++++++++++++
 tb/tb_lfsr_prbs_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_checker.sv
// Galois-LFSR PRBS checker: seeds from the stream, locks after a run of
// matches, then flywheels and counts word and bit errors while locked.
module lfsr_prbs_checker #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] POLY       = 8'h63,
    parameter int               LOCK_CNT   = 5,
    parameter int               UNLOCK_CNT = 3,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clr_cnt,
    output logic             o_lock,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_err_cnt
);

    localparam int MAXC = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = $clog2(WIDTH + 1);
    localparam int SW   = CNT_W + 1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SYNC     = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ref_q;
    logic [CW-1:0]    match_cnt;
    logic [CW-1:0]    miss_cnt;

    logic             fb;
    logic [WIDTH-1:0] exp_w;
    logic [WIDTH-1:0] diff;
    logic             hit;
    logic [PW-1:0]    pop;
    logic [CW-1:0]    match_inc;
    logic [CW-1:0]    miss_inc;
    logic [SW-1:0]    bit_sum;
    logic [CNT_W-1:0] err_nx;
    logic [CNT_W-1:0] bit_nx;

    // Expected word: one Galois step from the reference, zero state included
    always_comb begin
        fb        = ref_q[WIDTH-1] ^ (ref_q[WIDTH-2:0] == '0);
        exp_w     = (ref_q << 1) ^ (fb ? POLY : '0);
        diff      = i_data ^ exp_w;
        hit       = (diff == '0);
        match_inc = match_cnt + 1'b1;
        miss_inc  = miss_cnt + 1'b1;
    end

    // Number of errored bits in the current word
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(diff[i]);
        end
    end

    // Saturating next values for the error counters
    always_comb begin
        err_nx  = (&o_err_cnt) ? o_err_cnt : o_err_cnt + 1'b1;
        bit_sum = {1'b0, o_bit_err_cnt} + SW'(pop);
        bit_nx  = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end

    // Sync FSM, reference flywheel, error pulse and counters
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= UNLOCKED;
            ref_q         <= '0;
            match_cnt     <= '0;
            miss_cnt      <= '0;
            o_lock        <= 1'b0;
            o_err         <= 1'b0;
            o_err_cnt     <= '0;
            o_bit_err_cnt <= '0;
        end else begin
            o_err <= 1'b0;
            if (i_valid) begin
                unique case (state)
                    UNLOCKED: begin
                        ref_q     <= i_data;
                        match_cnt <= '0;
                        state     <= SYNC;
                    end
                    SYNC: begin
                        if (hit) begin
                            ref_q     <= exp_w;
                            match_cnt <= match_inc;
                            if (match_inc == CW'(LOCK_CNT)) begin
                                state  <= LOCKED;
                                o_lock <= 1'b1;
                            end
                        end else begin
                            ref_q     <= i_data;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        ref_q <= exp_w;
                        if (hit) begin
                            miss_cnt <= '0;
                        end else begin
                            o_err         <= 1'b1;
                            o_err_cnt     <= err_nx;
                            o_bit_err_cnt <= bit_nx;
                            if (miss_inc == CW'(UNLOCK_CNT)) begin
                                state    <= UNLOCKED;
                                o_lock   <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_inc;
                            end
                        end
                    end
                    default: begin
                        state  <= UNLOCKED;
                        o_lock <= 1'b0;
                    end
                endcase
            end
            if (i_clr_cnt) begin
                o_err_cnt     <= '0;
                o_bit_err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Scoreboarded random + directed bench for lfsr_prbs_checker.
// Reference model tracks lock state from the word-level rules.
module tb_lfsr_prbs_checker;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid;
    logic [7:0]    i_data;
    logic          i_clr_cnt;
    logic          o_lock;
    logic          o_err;
    logic [CW-1:0] o_err_cnt;
    logic [CW-1:0] o_bit_err_cnt;

    lfsr_prbs_checker #(
        .WIDTH     (8),
        .POLY      (8'h63),
        .LOCK_CNT  (5),
        .UNLOCK_CNT(3),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_clr_cnt    (i_clr_cnt),
        .o_lock       (o_lock),
        .o_err        (o_err),
        .o_err_cnt    (o_err_cnt),
        .o_bit_err_cnt(o_bit_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int lock;
        int err;
        int ec;
        int bc;
    } exp_t;

    exp_t q[$];
    int   cycle = 0;
    int   errs = 0;
    int   checks = 0;

    // model state: 0 unlocked, 1 sync, 2 locked
    int       mst;
    logic [7:0] mref;
    int       mm;
    int       mi;
    int       mlock;
    int       merr;
    int       mec;
    int       mbc;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string n, input int act, input int req);
        checks++;
        if (act != req) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                     n, cycle, act, req);
        end
    endtask

    function automatic logic [7:0] nx(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ (s[6:0] == 7'd0);
        return (s << 1) ^ (fb ? 8'h63 : 8'h00);
    endfunction

    function automatic int sat(input int v);
        return (v > (2**CW - 1)) ? (2**CW - 1) : v;
    endfunction

    task automatic m_reset();
        mst = 0; mref = 8'h00; mm = 0; mi = 0;
        mlock = 0; merr = 0; mec = 0; mbc = 0;
    endtask

    task automatic m_step(input logic v, input logic [7:0] d, input logic c);
        logic [7:0] e;
        exp_t       x;
        e    = nx(mref);
        merr = 0;
        if (v) begin
            if (mst == 0) begin
                mref = d; mm = 0; mst = 1;
            end else if (mst == 1) begin
                if (d == e) begin
                    mref = e; mm++;
                    if (mm == 5) mst = 2;
                end else begin
                    mref = d; mm = 0;
                end
            end else begin
                mref = e;
                if (d == e) begin
                    mi = 0;
                end else begin
                    merr = 1;
                    mec  = sat(mec + 1);
                    mbc  = sat(mbc + $countones(d ^ e));
                    mi++;
                    if (mi == 3) begin
                        mst = 0; mi = 0;
                    end
                end
            end
        end
        if (c) begin
            mec = 0; mbc = 0;
        end
        mlock = (mst == 2) ? 1 : 0;
        x.due = cycle + 1;
        x.lock = mlock; x.err = merr; x.ec = mec; x.bc = mbc;
        q.push_back(x);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        i_valid = v; i_data = d; i_clr_cnt = c;
        m_step(v, d, c);
    endtask

    task automatic good();
        cyc(1'b1, nx(mref), 1'b0);
    endtask

    task automatic bad(input logic [7:0] x);
        cyc(1'b1, nx(mref) ^ x, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        i_valid = 1'b0; i_clr_cnt = 1'b0;
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("rst_lock", int'(o_lock), 0);
        chk("rst_err", int'(o_err), 0);
        chk("rst_err_cnt", int'(o_err_cnt), 0);
        chk("rst_bit_cnt", int'(o_bit_err_cnt), 0);
        m_reset();
        #6;
        i_rst_n = 1'b1;
    endtask

    task automatic relock(input logic [7:0] seed);
        cyc(1'b1, seed, 1'b0);
        repeat (5) good();
    endtask

    // Monitor: compare every due expectation against the outputs
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cycle) begin
            exp_t e;
            e = q.pop_front();
            chk("lock", int'(o_lock), e.lock);
            chk("err", int'(o_err), e.err);
            chk("err_cnt", int'(o_err_cnt), e.ec);
            chk("bit_cnt", int'(o_bit_err_cnt), e.bc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       v;
        logic       c;
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = 8'h00; i_clr_cnt = 1'b0;
        m_reset();
        #12;
        chk("init_lock", int'(o_lock), 0);
        chk("init_err", int'(o_err), 0);
        chk("init_err_cnt", int'(o_err_cnt), 0);
        chk("init_bit_cnt", int'(o_bit_err_cnt), 0);
        #5;
        i_rst_n = 1'b1;

        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        cyc(1'b1, 8'h04, 1'b0);
        cyc(1'b1, 8'h08, 1'b0);
        cyc(1'b1, 8'h10, 1'b0);
        cyc(1'b1, 8'h20, 1'b0);
        cyc(1'b1, 8'h40, 1'b0);
        cyc(1'b1, 8'h80, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h60, 1'b0);
        repeat (3) good();
        cyc(1'b0, 8'h5a, 1'b0);
        good();

        bad(8'h01);
        bad(8'h02);
        bad(8'hff);
        cyc(1'b1, 8'h5a, 1'b0);
        repeat (5) begin
            cyc(1'b0, 8'($urandom), 1'b0);
            good();
        end
        good();
        cyc(1'b1, nx(mref) ^ 8'h11, 1'b1);
        good();
        bad(8'h81);
        good();

        repeat (800) begin
            v = ($urandom_range(0, 99) < 80);
            c = ($urandom_range(0, 59) == 0);
            if (!v || mst == 0) begin
                d = 8'($urandom);
            end else if ($urandom_range(0, 99) < 12) begin
                d = nx(mref) ^ 8'($urandom_range(1, 255));
            end else begin
                d = nx(mref);
            end
            cyc(v, d, c);
        end

        async_reset();
        relock(8'hc3);
        bad(8'h0f);
        good();
        async_reset();
        relock(8'h00);
        good();

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
